// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with a valid/ready handshake on both sides and a two-entry skid buffer.
// Every output is decoded from flops, so no combinational path crosses the stage boundary.
module pipe_stage_skid #(
  parameter int unsigned        DATA_W  = 32,
  parameter logic [DATA_W-1:0]  NOP_VAL = '0,
  parameter int unsigned        CNT_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] STALL_MAX = '1;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   main_q, main_d;
  logic [DATA_W-1:0]   skid_q, skid_d;
  logic [CNT_W-1:0]    stall_q, stall_d;
  logic                in_xfer;
  logic                out_xfer;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != FULL);
  assign out_data  = (state_q != EMPTY) ? main_q : NOP_VAL;
  assign occupancy = state_q;
  assign stall_cnt = stall_q;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    stall_d = stall_q;

    // main always holds the oldest entry; skid only fills when main cannot drain
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          main_d  = in_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = in_data;
        end else if (in_xfer) begin
          skid_d  = in_data;
          state_d = FULL;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (flush) begin
      state_d = EMPTY;
    end

    if (out_valid && !out_ready && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= EMPTY;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  // Payload registers carry no reset: their content is ignored while the stage is empty
  always_ff @(posedge clock) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed scenarios plus randomized traffic
// compared against a queue-based model of the stage.
module tb_pipe_stage_skid;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        flush;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [31:0] s_out_data;
  logic [1:0]  s_occupancy;
  logic [2:0]  s_stall_cnt;

  int tests_run;
  int tests_failed;

  logic [31:0] mq[$];
  int          m_stall;
  int          m_stall3;

  pipe_stage_skid dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_stage_skid #(.CNT_W(3)) dut_s (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .flush(flush), .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock: the model consumes the same inputs the DUT samples, outputs are read at negedge
  task automatic tick();
    bit ov;
    bit ir;
    @(posedge clock);
    ov = (mq.size() != 0);
    ir = (mq.size() < 2);
    if (reset) begin
      mq.delete();
      m_stall  = 0;
      m_stall3 = 0;
    end else begin
      if (ov && !out_ready) begin
        if (m_stall < 65535) m_stall++;
        if (m_stall3 < 7) m_stall3++;
      end
      if (ov && out_ready) void'(mq.pop_front());
      if (ir && in_valid) mq.push_back(in_data);
      if (flush) mq.delete();
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1; in_valid = 1; in_data = 32'h12345678; out_ready = 0; flush = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests_run++;
      if ({out_valid, in_ready, occupancy} !== 4'b0100 || out_data !== 32'h0 || stall_cnt !== 16'd0) begin
        tests_failed++;
        $display("[TB] FAIL reset_during: valid=%b ready=%b occ=%0d data=%h stall=%0d, required 0 1 0 00000000 0",
                 out_valid, in_ready, occupancy, out_data, stall_cnt);
      end
    end
    reset = 0; in_valid = 0;
    tick();
    tests_run++;
    if ({out_valid, in_ready, occupancy} !== 4'b0100 || out_data !== 32'h0 || stall_cnt !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_after: valid=%b ready=%b occ=%0d data=%h stall=%0d, required 0 1 0 00000000 0",
               out_valid, in_ready, occupancy, out_data, stall_cnt);
    end
  endtask

  task automatic test_streaming();
    out_ready = 1; in_valid = 1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 32'(i);
      tick();
      tests_run++;
      if (out_data !== 32'(i) || occupancy !== 2'd1 || out_valid !== 1'b1 || stall_cnt !== 16'd0) begin
        tests_failed++;
        $display("[TB] FAIL streaming_%0d: data=%h occ=%0d valid=%b stall=%0d, required %h 1 1 0",
                 i, out_data, occupancy, out_valid, stall_cnt, 32'(i));
      end
    end
    in_valid = 0;
    tick();
    tests_run++;
    if (occupancy !== 2'd0 || out_data !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL streaming_drain: occ=%0d data=%h, required 0 00000000", occupancy, out_data);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0]  exp_occ   [5] = '{2'd1, 2'd2, 2'd2, 2'd1, 2'd0};
    logic        exp_ready [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] exp_data  [5] = '{32'hA, 32'hA, 32'hA, 32'hB, 32'h0};
    logic [15:0] exp_stall [5] = '{16'd0, 16'd1, 16'd2, 16'd2, 16'd2};
    logic        drv_valid [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] drv_data  [5] = '{32'hA, 32'hB, 32'h0, 32'h0, 32'h0};
    logic        drv_ready [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      in_valid = drv_valid[i]; in_data = drv_data[i]; out_ready = drv_ready[i];
      tick();
      tests_run++;
      if (occupancy !== exp_occ[i] || in_ready !== exp_ready[i] || out_data !== exp_data[i] || stall_cnt !== exp_stall[i]) begin
        tests_failed++;
        $display("[TB] FAIL backpressure_%0d: occ=%0d ready=%b data=%h stall=%0d, required %0d %b %h %0d",
                 i, occupancy, in_ready, out_data, stall_cnt, exp_occ[i], exp_ready[i], exp_data[i], exp_stall[i]);
      end
    end
  endtask

  task automatic test_flush_full();
    out_ready = 0; in_valid = 1; in_data = 32'hA;
    tick();
    in_data = 32'hB;
    tick();
    tests_run++;
    if (occupancy !== 2'd2 || stall_cnt !== 16'd3) begin
      tests_failed++;
      $display("[TB] FAIL flush_setup: occ=%0d stall=%0d, required 2 3", occupancy, stall_cnt);
    end
    flush = 1; in_data = 32'hC;
    tick();
    flush = 0; in_valid = 0;
    tests_run++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0 || stall_cnt !== 16'd4) begin
      tests_failed++;
      $display("[TB] FAIL flush_full: occ=%0d valid=%b ready=%b data=%h stall=%0d, required 0 0 1 00000000 4",
               occupancy, out_valid, in_ready, out_data, stall_cnt);
    end
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (out_valid !== 1'b0 || out_data === 32'hC) begin
        tests_failed++;
        $display("[TB] FAIL flush_discard_%0d: valid=%b data=%h, required 0 and never 0000000c", i, out_valid, out_data);
      end
    end
  endtask

  task automatic test_simultaneous();
    out_ready = 0; in_valid = 1; in_data = 32'h5;
    tick();
    tests_run++;
    if (occupancy !== 2'd1 || out_data !== 32'h5) begin
      tests_failed++;
      $display("[TB] FAIL simul_setup: occ=%0d data=%h, required 1 00000005", occupancy, out_data);
    end
    out_ready = 1; in_data = 32'h6;
    tick();
    in_valid = 0;
    tests_run++;
    if (occupancy !== 2'd1 || out_data !== 32'h6 || stall_cnt !== 16'd4) begin
      tests_failed++;
      $display("[TB] FAIL simul_xfer: occ=%0d data=%h stall=%0d, required 1 00000006 4", occupancy, out_data, stall_cnt);
    end
    tick();
  endtask

  task automatic test_saturation();
    reset = 1; flush = 0; in_valid = 0; out_ready = 0;
    tick();
    reset = 0; in_valid = 1; in_data = 32'h77;
    tick();
    in_valid = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      tests_run++;
      if (s_stall_cnt !== 3'((k > 7) ? 7 : k) || stall_cnt !== 16'(k)) begin
        tests_failed++;
        $display("[TB] FAIL saturation_%0d: stall3=%0d stall16=%0d, required %0d %0d",
                 k, s_stall_cnt, stall_cnt, (k > 7) ? 7 : k, k);
      end
    end
    flush = 1;
    tick();
    flush = 0; out_ready = 1;
    tick();
    tests_run++;
    if (s_stall_cnt !== 3'd7 || stall_cnt !== 16'd11 || s_occupancy !== 2'd0) begin
      tests_failed++;
      $display("[TB] FAIL saturation_flush: stall3=%0d stall16=%0d occ=%0d, required 7 11 0",
               s_stall_cnt, stall_cnt, s_occupancy);
    end
    reset = 1;
    tick();
    reset = 0;
    tests_run++;
    if (s_stall_cnt !== 3'd0 || stall_cnt !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL saturation_reset: stall3=%0d stall16=%0d, required 0 0", s_stall_cnt, stall_cnt);
    end
  endtask

  task automatic test_random();
    logic [1:0]  exp_occ;
    logic [31:0] exp_data;
    reset = 1; flush = 0; in_valid = 0; out_ready = 0;
    tick();
    reset = 0;
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 15) == 0);
      reset     = ($urandom_range(0, 99) == 0);
      in_data   = $urandom;
      tick();
      exp_occ  = 2'(mq.size());
      exp_data = (mq.size() != 0) ? mq[0] : 32'h0;
      tests_run++;
      if (occupancy !== exp_occ || out_valid !== (exp_occ != 0) || in_ready !== (exp_occ != 2) ||
          out_data !== exp_data || stall_cnt !== 16'(m_stall) || s_stall_cnt !== 3'(m_stall3)) begin
        tests_failed++;
        $display("[TB] FAIL random_%0d: occ=%0d valid=%b ready=%b data=%h stall=%0d stall3=%0d, required %0d %b %b %h %0d %0d",
                 i, occupancy, out_valid, in_ready, out_data, stall_cnt, s_stall_cnt,
                 exp_occ, exp_occ != 0, exp_occ != 2, exp_data, m_stall, m_stall3);
      end
    end
    reset = 0; flush = 0; in_valid = 0; out_ready = 0;
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    m_stall = 0; m_stall3 = 0;
    reset = 0; in_valid = 0; in_data = '0; out_ready = 0; flush = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_full();
    test_simultaneous();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register for the MipsCPU pipeline, replacing the fixed IF2ID/ID2EXE/EXE2MEM/MEM2WB latches with one generic block. It carries an arbitrary-width payload across a stage boundary with a valid/ready handshake on both sides, a two-entry skid buffer, a synchronous flush, bubble insertion and a saturating stall counter. All outputs come directly from flops, so no combinational path crosses the stage boundary.

## Interface
- DATA_W, 32, payload width in bits: packed PC, instruction, control and data fields of the stage.
- NOP_VAL, 0 (DATA_W bits), value driven on out_data whenever the stage holds nothing (the bubble).
- CNT_W, 16, width of the stall counter.

- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream presents a payload.
- in_ready  output  1  stage can accept a payload this cycle.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  stage presents a payload.
- out_ready  input  1  downstream consumes the payload this cycle.
- out_data  output  DATA_W  payload, or NOP_VAL when empty.
- flush  input  1  discard all held entries, for example on a taken branch.
- occupancy  output  2  number of held entries: 0, 1 or 2.
- stall_cnt  output  CNT_W  count of cycles with out_valid=1 and out_ready=0.

## Operation
- Storage is two registers, main and skid, plus a 2-bit occupancy register.
- A transfer happens on the input when in_valid=1 and in_ready=1, and on the output when out_valid=1 and out_ready=1.
- Decoded outputs:
  - out_valid = (occupancy != 0).
  - in_ready = (occupancy != 2).
  - out_data = main when occupancy != 0, otherwise NOP_VAL.
- State EMPTY (occupancy 0):
  - input transfer: main <= in_data; go to ONE.
  - otherwise: stay in EMPTY.
- State ONE (occupancy 1):
  - input and output transfer together: main <= in_data; stay in ONE.
  - input transfer only: skid <= in_data; go to FULL.
  - output transfer only: go to EMPTY.
  - neither: hold.
- State FULL (occupancy 2):
  - in_ready=0, so no input transfer is possible.
  - output transfer: main <= skid; go to ONE.
  - otherwise: hold.
- Order is preserved: main is always older than skid.
- Flush has priority over every other event. The next state is EMPTY regardless of current state or handshakes. An input transfer in the flush cycle counts as consumed by upstream but is discarded. An output transfer in the flush cycle still completes, because downstream has already sampled main.
- stall_cnt:
  - increments by 1 in each cycle with out_valid=1 and out_ready=0, including flush cycles.
  - saturates at 2^CNT_W-1 with no wrap.
  - is cleared only by reset; flush does not clear it.
- Data registers update only on their load conditions, and are not cleared by flush.

## Timing
- Reset values: occupancy=0, out_valid=0, in_ready=1, out_data=NOP_VAL, stall_cnt=0. main and skid are don't-care.
- Reset in mid-operation discards both entries at the next edge; the outputs take their reset values the cycle after reset is sampled.
- Latency: a payload accepted at edge N appears on out_data and out_valid after edge N, so it is visible in cycle N+1.
- Throughput: one payload per cycle when out_ready is held at 1. Occupancy then stays at 1 and skid is never used.
- Backpressure:
  - in_ready drops one cycle after skid is loaded.
  - upstream may present one extra payload in the cycle out_ready falls; it is absorbed by skid without loss.
- Flush: out_valid=0 and out_data=NOP_VAL in the cycle after flush is sampled. in_ready=1 in that same cycle.
- No input-to-output combinational path exists. All of in_ready, out_valid, out_data, occupancy and stall_cnt are register-decoded.

## Test plan
- Reset: assert reset for 2 cycles while in_valid=1 and in_data=0x12345678. Required: out_valid=0, in_ready=1, out_data=0x00000000, occupancy=0 and stall_cnt=0 during and after reset.
- Streaming: hold out_ready=1 and send 0x1, 0x2, 0x3, 0x4 on consecutive cycles. Required: the same sequence on out_data one cycle later, occupancy stays at 1, stall_cnt=0.
- Backpressure fill: hold out_ready=0 and send 0xA then 0xB. Required: occupancy goes 1 then 2; in_ready=0 after 0xB; stall_cnt counts 1, 2, … Then raise out_ready=1. Required: 0xA and then 0xB are output with no loss and no duplicate, and in_ready returns to 1.
- Flush while FULL: with 0xA and 0xB held, assert flush for one cycle while in_valid=1 and in_data=0xC. Required: next cycle occupancy=0, out_valid=0, out_data=NOP_VAL; 0xC never appears on out_data.
- Simultaneous transfers in ONE: hold 0x5, assert out_ready=1 and in_valid=1 with in_data=0x6. Required: the next cycle shows occupancy=1 and out_data=0x6.
- Saturation: with CNT_W=3, hold out_valid=1 and out_ready=0 for 10 cycles. Required: stall_cnt stops at 7; a subsequent flush leaves it at 7; only reset returns it to 0.
